// File: rtl/la_headerseq.sv
// Power-gating sequencer for an N-segment la_header domain: staggers header
// switching, drives isolation/retention and waits for power-good with a timeout.
module la_headerseq #(
    parameter int N       = 4,
    parameter int STEP    = 2,
    parameter int ISO_DLY = 2,
    parameter int RET_DLY = 1,
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 16,
    parameter     PROP    = "DEFAULT"
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         on_req,
    input  logic         pwr_ok,
    output logic [N-1:0] sleep,
    output logic         iso,
    output logic         ret,
    output logic         on_ack,
    output logic         off_ack,
    output logic         err
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXV = max_of(max_of(STEP * N, ISO_DLY), max_of(RET_DLY, TIMEOUT));
    localparam int CW   = $clog2(MAXV + 1);

    localparam logic [CW-1:0] STEP_C    = CW'(STEP);
    localparam logic [CW-1:0] N_C       = CW'(N);
    localparam logic [CW-1:0] ISO_C     = CW'(ISO_DLY);
    localparam logic [CW-1:0] RET_C     = CW'(RET_DLY);
    localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    localparam logic [3:0] S_OFF     = 4'd0;
    localparam logic [3:0] S_UNGATE  = 4'd1;
    localparam logic [3:0] S_SETTLE  = 4'd2;
    localparam logic [3:0] S_RESTORE = 4'd3;
    localparam logic [3:0] S_DEISO   = 4'd4;
    localparam logic [3:0] S_ON      = 4'd5;
    localparam logic [3:0] S_ISO     = 4'd6;
    localparam logic [3:0] S_SAVE    = 4'd7;
    localparam logic [3:0] S_GATE    = 4'd8;

    logic [3:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] idx_r;
    logic          block_r;

    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] idx_inc;
    logic [N-1:0]  seg_bit;

    // cnt_inc is the number of cycles spent in the current state including this edge
    assign cnt_inc = cnt_r + CW'(1);
    assign idx_inc = idx_r + CW'(1);
    assign seg_bit = N'(1) << idx_inc;

    // Sequencer state, step counters and all registered outputs
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r <= S_OFF;
            cnt_r   <= '0;
            idx_r   <= '0;
            block_r <= 1'b0;
            sleep   <= {N{1'b1}};
            iso     <= 1'b1;
            ret     <= 1'b0;
            on_ack  <= 1'b0;
            off_ack <= 1'b1;
            err     <= 1'b0;
        end else begin
            case (state_r)
                S_OFF: begin
                    if (!on_req) begin
                        block_r <= 1'b0;
                    end else if (!block_r) begin
                        state_r  <= S_UNGATE;
                        off_ack  <= 1'b0;
                        err      <= 1'b0;
                        cnt_r    <= '0;
                        idx_r    <= '0;
                        sleep[0] <= 1'b0;
                    end else begin
                        state_r <= S_OFF;
                    end
                end
                S_UNGATE: begin
                    if (cnt_inc == STEP_C) begin
                        cnt_r <= '0;
                        if (idx_inc == N_C) begin
                            state_r <= S_SETTLE;
                        end else begin
                            idx_r <= idx_inc;
                            sleep <= sleep & ~seg_bit;
                        end
                    end else begin
                        cnt_r <= cnt_inc;
                    end
                end
                S_SETTLE: begin
                    // acceptance is tested first so it wins over a same-edge timeout
                    if ((cnt_inc >= SETTLE_C) && pwr_ok) begin
                        state_r <= S_RESTORE;
                        ret     <= 1'b0;
                        cnt_r   <= '0;
                    end else if (cnt_inc >= TIMEOUT_C) begin
                        state_r  <= S_GATE;
                        err      <= 1'b1;
                        block_r  <= 1'b1;
                        cnt_r    <= '0;
                        idx_r    <= '0;
                        sleep[0] <= 1'b1;
                    end else begin
                        cnt_r <= cnt_inc;
                    end
                end
                S_RESTORE: begin
                    if (cnt_inc == RET_C) begin
                        state_r <= S_DEISO;
                        iso     <= 1'b0;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_inc;
                    end
                end
                S_DEISO: begin
                    if (cnt_inc == ISO_C) begin
                        state_r <= S_ON;
                        on_ack  <= 1'b1;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_inc;
                    end
                end
                S_ON: begin
                    if (!on_req) begin
                        state_r <= S_ISO;
                        iso     <= 1'b1;
                        on_ack  <= 1'b0;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= S_ON;
                    end
                end
                S_ISO: begin
                    if (cnt_inc == ISO_C) begin
                        state_r <= S_SAVE;
                        ret     <= 1'b1;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_inc;
                    end
                end
                S_SAVE: begin
                    if (cnt_inc == RET_C) begin
                        state_r  <= S_GATE;
                        cnt_r    <= '0;
                        idx_r    <= '0;
                        sleep[0] <= 1'b1;
                    end else begin
                        cnt_r <= cnt_inc;
                    end
                end
                S_GATE: begin
                    if (cnt_inc == STEP_C) begin
                        cnt_r <= '0;
                        if (idx_inc == N_C) begin
                            state_r <= S_OFF;
                            off_ack <= 1'b1;
                        end else begin
                            idx_r <= idx_inc;
                            sleep <= sleep | seg_bit;
                        end
                    end else begin
                        cnt_r <= cnt_inc;
                    end
                end
                default: begin
                    state_r <= S_OFF;
                    cnt_r   <= '0;
                    idx_r   <= '0;
                    sleep   <= {N{1'b1}};
                    iso     <= 1'b1;
                    on_ack  <= 1'b0;
                    off_ack <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_la_headerseq.sv
// Self-checking bench for la_headerseq: directed sequences plus random traffic,
// compared every cycle against a timeline model of the power sequences.
module tb_la_headerseq;

    localparam int N       = 4;
    localparam int STEP    = 2;
    localparam int ISO_DLY = 2;
    localparam int RET_DLY = 1;
    localparam int SETTLE  = 3;
    localparam int TIMEOUT = 16;

    localparam int M_OFF  = 0;
    localparam int M_UP   = 1;
    localparam int M_WAIT = 2;
    localparam int M_POST = 3;
    localparam int M_ON   = 4;
    localparam int M_DOWN = 5;

    logic         clk = 1'b0;
    logic         nreset;
    logic         on_req;
    logic         pwr_ok;
    logic [N-1:0] sleep;
    logic         iso;
    logic         ret;
    logic         on_ack;
    logic         off_ack;
    logic         err;

    int compared   = 0;
    int mismatched = 0;

    // reference model: mode plus absolute edge times of sequence milestones
    int n    = 0;
    int mode = M_OFF;
    int t0   = 0;
    int ts   = 0;
    int t1   = 0;
    int tg   = 0;
    bit m_err   = 1'b0;
    bit m_block = 1'b0;
    bit m_ret   = 1'b0;

    logic [N-1:0] e_sleep;
    logic         e_iso;

    la_headerseq #(
        .N(N), .STEP(STEP), .ISO_DLY(ISO_DLY), .RET_DLY(RET_DLY),
        .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .PROP("DEFAULT")
    ) dut (
        .clk(clk), .nreset(nreset), .on_req(on_req), .pwr_ok(pwr_ok),
        .sleep(sleep), .iso(iso), .ret(ret), .on_ack(on_ack),
        .off_ack(off_ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic model_step();
        n++;
        if (!nreset) begin
            mode    = M_OFF;
            m_err   = 1'b0;
            m_block = 1'b0;
            m_ret   = 1'b0;
        end else begin
            case (mode)
                M_OFF: begin
                    if (!on_req) m_block = 1'b0;
                    else if (!m_block) begin
                        mode  = M_UP;
                        t0    = n;
                        m_err = 1'b0;
                    end
                end
                M_UP: if (n - t0 == N * STEP) begin
                    mode = M_WAIT;
                    ts   = n;
                end
                M_WAIT: begin
                    if ((n - ts >= SETTLE) && pwr_ok) begin
                        mode  = M_POST;
                        t1    = n;
                        m_ret = 1'b0;
                    end else if (n - ts >= TIMEOUT) begin
                        m_err   = 1'b1;
                        m_block = 1'b1;
                        mode    = M_DOWN;
                        tg      = n;
                        t0      = n - ISO_DLY - RET_DLY;
                    end
                end
                M_POST: if (n - t1 == RET_DLY + ISO_DLY) mode = M_ON;
                M_ON: if (!on_req) begin
                    mode = M_DOWN;
                    t0   = n;
                    tg   = n + ISO_DLY + RET_DLY;
                end
                M_DOWN: begin
                    if (n == t0 + ISO_DLY) m_ret = 1'b1;
                    if (n - tg == N * STEP) mode = M_OFF;
                end
                default: mode = M_OFF;
            endcase
        end

        e_sleep = {N{1'b1}};
        e_iso   = 1'b1;
        case (mode)
            M_UP:   for (int i = 0; i < N; i++) e_sleep[i] = (i * STEP > n - t0);
            M_WAIT: e_sleep = '0;
            M_POST: begin
                e_sleep = '0;
                e_iso   = (n - t1 < RET_DLY);
            end
            M_ON: begin
                e_sleep = '0;
                e_iso   = 1'b0;
            end
            M_DOWN: for (int i = 0; i < N; i++) e_sleep[i] = (n >= tg) && (n - tg >= i * STEP);
            default: e_sleep = {N{1'b1}};
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("sleep", 32'(sleep), 32'(e_sleep));
        check("iso", 32'(iso), 32'(e_iso));
        check("ret", 32'(ret), 32'(m_ret));
        check("on_ack", 32'(on_ack), 32'(mode == M_ON));
        check("off_ack", 32'(off_ack), 32'(mode == M_OFF));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic check_reset_vec(input string tag);
        check(tag, 32'({sleep, iso, ret, on_ack, off_ack, err}),
              32'({4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}));
    endtask

    int pmode;

    initial begin
        nreset = 1'b0;
        on_req = 1'b0;
        pwr_ok = 1'b0;
        #2;
        run(2);
        check_reset_vec("reset_vec");
        nreset = 1'b1;
        run(2);

        // power-up with pwr_ok noise during ungate, then steady good
        on_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pwr_ok = 1'($urandom_range(0, 1));
            cycle();
        end
        pwr_ok = 1'b1;
        run(10);
        check("on_after_up", 32'(on_ack), 32'd1);

        // power-down from ON
        on_req = 1'b0;
        run(14);
        check("off_after_down", 32'(off_ack), 32'd1);

        // timeout: no pwr_ok, then blocked while on_req stays high
        pwr_ok = 1'b0;
        on_req = 1'b1;
        run(45);
        check("err_sticky", 32'(err), 32'd1);
        on_req = 1'b0;
        run(2);
        on_req = 1'b1;
        pwr_ok = 1'b1;
        cycle();
        check("err_cleared", 32'(err), 32'd0);
        run(18);

        // on_req toggled inside the power-down, honoured afterwards
        on_req = 1'b0;
        cycle();
        on_req = 1'b1;
        run(32);
        on_req = 1'b0;
        run(4);
        on_req = 1'b1;
        run(30);

        // reset in the middle of ungating
        on_req = 1'b0;
        run(14);
        on_req = 1'b1;
        run(3);
        nreset = 1'b0;
        cycle();
        check_reset_vec("reset_mid_ungate");
        nreset = 1'b1;
        on_req = 1'b0;
        run(3);

        // random traffic
        pmode = 0;
        for (int c = 0; c < 800; c++) begin
            if (c % 40 == 0) pmode = int'($urandom_range(0, 2));
            pwr_ok = (pmode == 2) ? 1'b1 : (pmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if ($urandom_range(0, 24) == 0) on_req = ~on_req;
            nreset = ($urandom_range(0, 199) != 0);
            cycle();
        end
        nreset = 1'b1;
        run(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
